neuron_event_rx: RTL and testbench
==================================

# neuron_event_rx

Registered, parametrised front end for the neuron event stream. It takes the byte-wide event bus and config side-bus, decodes each accepted word into a spike/tick event or a special command, and buffers spike/tick events in a small FIFO with a ready/valid output. It also assembles two-nibble configuration writes, emits one-cycle command strobes, and counts events dropped on overflow. It sits between the pin-level input registers and the neuron core / config register file.

## Interface
Parameters:
- ADDR_W, 6, neuron address width; event word width is ADDR_W+2.
- CFG_W, 4, config argument width; cfg_data is 2*CFG_W.
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2.
- ADDR_RESET, all-ones (63), reserved address for the reset command.
- ADDR_ARM, all-ones−1 (62), reserved address for the arm command.
- ADDR_CFG, all-ones−2 (61), reserved address for the config command.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/uio_data hold a word this cycle.
- in_data  input  ADDR_W+2  bit MSB = tick flag, MSB−1 = polarity, [ADDR_W−1:0] = address.
- uio_data  input  CFG_W+4  [CFG_W+3:4] = cfg argument, [3:2] = cfg op, [1:0] ignored.
- ev_valid  output  1  FIFO head valid.
- ev_ready  input  1  consumer accepts head.
- ev_tick, ev_polarity  output  1 each  head fields.
- ev_addr  output  ADDR_W  head address.
- cmd_reset, cmd_arm  output  1 each  one-cycle command strobes.
- cfg_we  output  1  one-cycle config write strobe.
- cfg_op  output  2  op of the completed config write.
- cfg_data  output  2*CFG_W  {high nibble, low nibble}.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  occupancy.
- drop_count  output  8  saturating overflow counter.

## Operation
- Accept a word when in_valid=1 at the rising edge. With in_valid=0, no state changes except pops.
- Tick flag set: the word is an event, whatever the address, including the reserved addresses.
- Tick flag clear:
  - address == ADDR_RESET: reset command.
  - address == ADDR_ARM: arm command.
  - address == ADDR_CFG: config command.
  - any other address: event.
- Events (tick or spike) are pushed to the FIFO as {tick, polarity, addr}. Order is preserved across ticks and spikes.
- Reset command: pulse cmd_reset. Clear the config staging flag. FIFO contents are untouched.
- Arm command: pulse cmd_arm only.
- Config command with op = 2'b11 (prefix): store the argument in the staging nibble and set stage_v. No cfg_we. A second prefix overwrites the staged nibble.
- Config command with op ≠ 2'b11: pulse cfg_we with cfg_op = op and cfg_data = {stage_v ? staged : 0, arg}, then clear stage_v.
- FIFO:
  - Push on an accepted event while not full.
  - Pop when ev_valid && ev_ready.
  - Full with no pop in the same cycle: the event is dropped and drop_count increments, saturating at 255.
  - Full with a pop in the same cycle: the push is accepted and the level is unchanged.
  - Empty with a push: ev_valid rises the next cycle. There is no bypass.
- Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.

## Timing
- Reset (async assert, sync-safe release) drives all outputs to 0: ev_valid, ev_*, cmd_*, cfg_we, cfg_op, cfg_data, fifo_level, drop_count. It also clears stage_v, the staged nibble and the FIFO pointers. Reset mid-operation discards the FIFO contents and any pending prefix.
- Command latency is 1 cycle: a word accepted at edge N produces its cmd_*/cfg_we high for exactly the cycle after edge N. These strobes are registered.
- cfg_op/cfg_data are valid while cfg_we=1 and hold their last value otherwise.
- Event latency is 1 cycle into an empty FIFO.
- The ev_* fields are the FIFO head and are stable while ev_valid=1 && ev_ready=0.
- Back-to-back in_valid is sustained at one word per cycle. Commands never stall and never occupy the FIFO.
- fifo_level and drop_count update at the same edge as the push/pop/drop.

## Test plan
- Reset then idle: all outputs 0. Then in_data=0x05 (spike, addr 5) with ev_ready=0 → next cycle ev_valid=1, ev_addr=5, ev_polarity=0, ev_tick=0, fifo_level=1.
- Tick with reserved address: in_data=0xBF (tick, addr 63) → queued as event with ev_tick=1, ev_addr=63; cmd_reset stays 0. Then 0x3F → cmd_reset pulses one cycle and fifo_level is unchanged.
- Config assembly: ADDR_CFG word with uio_data=0xA0|(3<<2), then with uio_data=0x50|(1<<2) → the first produces no cfg_we; the second produces cfg_we=1, cfg_op=1, cfg_data=0xA5. A following unprefixed cfg with arg 7, op 2 → cfg_data=0x07.
- Prefix cancelled: prefix 0xC, reset command, then cfg arg 3 op 0 → cfg_data=0x03 and cmd_reset seen once.
- Overflow: ev_ready=0, push 6 spikes (addr 1..6) with FIFO_DEPTH=4 → fifo_level=4 and drop_count=2. Draining then yields addrs 1,2,3,4 in order. Push 300 more while full → drop_count=255.
- Full with concurrent pop: FIFO full, ev_ready=1 while pushing addr 9 → level stays 4 and drop_count is unchanged. Addr 9 emerges last. Asserting rst_n=0 mid-stream → ev_valid=0 and fifo_level=0 immediately.

Source files
------------

// File: rtl/neuron_event_rx.sv
// neuron_event_rx: front end for the neuron event stream.
// Decodes accepted words into spike/tick events, buffered in a small FIFO
// with a ready/valid head, or into reset/arm/config commands. Config writes
// can be prefixed with a staged high nibble. Events arriving while the FIFO
// is full and not popping are dropped and counted, saturating at 255.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid, in_data          input word {tick, polarity, addr}
//   uio_data                   {cfg arg, cfg op, 2 unused bits}
//   ev_valid/ev_ready          FIFO head handshake
//   ev_tick/ev_polarity/ev_addr FIFO head fields
//   cmd_reset, cmd_arm         one-cycle command strobes
//   cfg_we, cfg_op, cfg_data   one-cycle config write and its payload
//   fifo_level, drop_count     FIFO occupancy, saturating drop counter
module neuron_event_rx #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned CFG_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_RESET = (1 << ADDR_W) - 1,
  parameter int unsigned ADDR_ARM   = (1 << ADDR_W) - 2,
  parameter int unsigned ADDR_CFG   = (1 << ADDR_W) - 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [ADDR_W+1:0]               in_data,
  input  logic [CFG_W+3:0]                uio_data,
  output logic                            ev_valid,
  input  logic                            ev_ready,
  output logic                            ev_tick,
  output logic                            ev_polarity,
  output logic [ADDR_W-1:0]               ev_addr,
  output logic                            cmd_reset,
  output logic                            cmd_arm,
  output logic                            cfg_we,
  output logic [1:0]                      cfg_op,
  output logic [2*CFG_W-1:0]              cfg_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [7:0]                      drop_count
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned EV_W   = ADDR_W + 2;
  localparam int unsigned DATA_W = 2 * CFG_W;

  // Word field decode
  logic              in_tick;
  logic [ADDR_W-1:0] in_addr;
  logic [CFG_W-1:0]  cfg_arg;
  logic [1:0]        in_op;
  logic              unused_c;

  assign in_tick  = in_data[ADDR_W+1];
  assign in_addr  = in_data[ADDR_W-1:0];
  assign cfg_arg  = uio_data[CFG_W+3:4];
  assign in_op    = uio_data[3:2];
  assign unused_c = ^uio_data[1:0];

  // State
  logic [EV_W-1:0]   mem_q [FIFO_DEPTH];
  logic [EV_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [EV_W-1:0]   head_q, head_d;
  logic              ev_valid_q, ev_valid_d;
  logic [7:0]        drop_q, drop_d;
  logic              stage_v_q, stage_v_d;
  logic [CFG_W-1:0]  stage_q, stage_d;
  logic              cmd_reset_q, cmd_reset_d;
  logic              cmd_arm_q, cmd_arm_d;
  logic              cfg_we_q, cfg_we_d;
  logic [1:0]        cfg_op_q, cfg_op_d;
  logic [DATA_W-1:0] cfg_data_q, cfg_data_d;

  logic is_reset, is_arm, is_cfg, is_event;
  logic full, pop, push, drop;

  // Classification: a set tick flag always makes an event, even on reserved addresses
  always_comb begin
    is_reset = in_valid && !in_tick && (in_addr == ADDR_W'(ADDR_RESET));
    is_arm   = in_valid && !in_tick && (in_addr == ADDR_W'(ADDR_ARM));
    is_cfg   = in_valid && !in_tick && (in_addr == ADDR_W'(ADDR_CFG));
    is_event = in_valid && !(is_reset || is_arm || is_cfg);
  end

  // FIFO control: a pop in the same cycle frees a slot for a push into a full FIFO
  always_comb begin
    full = (level_q == LVL_W'(FIFO_DEPTH));
    pop  = ev_valid_q && ev_ready;
    push = is_event && (!full || pop);
    drop = is_event && full && !pop;
  end

  // FIFO next state; head is registered from the post-update storage
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
    head_d     = mem_d[rd_ptr_d];
    ev_valid_d = (level_d != '0);
  end

  // Commands and config assembly
  always_comb begin
    cmd_reset_d = is_reset;
    cmd_arm_d   = is_arm;
    cfg_we_d    = 1'b0;
    cfg_op_d    = cfg_op_q;
    cfg_data_d  = cfg_data_q;
    stage_v_d   = stage_v_q;
    stage_d     = stage_q;
    if (is_reset) begin
      stage_v_d = 1'b0;
    end
    if (is_cfg) begin
      if (in_op == 2'b11) begin
        stage_d   = cfg_arg;
        stage_v_d = 1'b1;
      end else begin
        cfg_we_d   = 1'b1;
        cfg_op_d   = in_op;
        cfg_data_d = {(stage_v_q ? stage_q : CFG_W'(0)), cfg_arg};
        stage_v_d  = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      head_q      <= '0;
      ev_valid_q  <= 1'b0;
      drop_q      <= '0;
      stage_v_q   <= 1'b0;
      stage_q     <= '0;
      cmd_reset_q <= 1'b0;
      cmd_arm_q   <= 1'b0;
      cfg_we_q    <= 1'b0;
      cfg_op_q    <= '0;
      cfg_data_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      head_q      <= head_d;
      ev_valid_q  <= ev_valid_d;
      drop_q      <= drop_d;
      stage_v_q   <= stage_v_d;
      stage_q     <= stage_d;
      cmd_reset_q <= cmd_reset_d;
      cmd_arm_q   <= cmd_arm_d;
      cfg_we_q    <= cfg_we_d;
      cfg_op_q    <= cfg_op_d;
      cfg_data_q  <= cfg_data_d;
    end
  end

  assign ev_valid    = ev_valid_q;
  assign ev_tick     = head_q[ADDR_W+1];
  assign ev_polarity = head_q[ADDR_W];
  assign ev_addr     = head_q[ADDR_W-1:0];
  assign cmd_reset   = cmd_reset_q;
  assign cmd_arm     = cmd_arm_q;
  assign cfg_we      = cfg_we_q;
  assign cfg_op      = cfg_op_q;
  assign cfg_data    = cfg_data_q;
  assign fifo_level  = level_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_neuron_event_rx.sv
// tb_neuron_event_rx: directed test-plan scenarios plus a random stream,
// checked every cycle against a queue-based reference model.
module tb_neuron_event_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [7:0] uio_data = '0;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_tick, ev_polarity;
  logic [5:0] ev_addr;
  logic       cmd_reset, cmd_arm, cfg_we;
  logic [1:0] cfg_op;
  logic [7:0] cfg_data;
  logic [2:0] fifo_level;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;

  neuron_event_rx dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .uio_data(uio_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_tick(ev_tick), .ev_polarity(ev_polarity), .ev_addr(ev_addr),
    .cmd_reset(cmd_reset), .cmd_arm(cmd_arm), .cfg_we(cfg_we),
    .cfg_op(cfg_op), .cfg_data(cfg_data), .fifo_level(fifo_level),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] q[$];
  int         m_drops = 0;
  bit         m_stage_v = 0;
  int         m_stage = 0;
  bit         m_reset = 0, m_arm = 0, m_we = 0;
  int         m_op = 0, m_data = 0;
  int         reset_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_drops = 0; m_stage_v = 0; m_stage = 0;
    m_reset = 0; m_arm = 0; m_we = 0; m_op = 0; m_data = 0;
  endtask

  task automatic check_all();
    chk("ev_valid", 32'(ev_valid), 32'(q.size() > 0));
    chk("fifo_level", 32'(fifo_level), 32'(q.size()));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
    chk("cmd_reset", 32'(cmd_reset), 32'(m_reset));
    chk("cmd_arm", 32'(cmd_arm), 32'(m_arm));
    chk("cfg_we", 32'(cfg_we), 32'(m_we));
    chk("cfg_op", 32'(cfg_op), 32'(m_op));
    chk("cfg_data", 32'(cfg_data), 32'(m_data));
    if (q.size() > 0) begin
      chk("ev_tick", 32'(ev_tick), 32'(q[0][7]));
      chk("ev_polarity", 32'(ev_polarity), 32'(q[0][6]));
      chk("ev_addr", 32'(ev_addr), 32'(q[0][5:0]));
    end
  endtask

  // One clock: drive inputs, advance the model by the word rules, compare.
  task automatic step(input bit v, input logic [7:0] d, input logic [7:0] u, input bit r);
    bit pop;
    int addr, op, arg;
    in_valid = v; in_data = d; uio_data = u; ev_ready = r;
    pop = (q.size() > 0) && r;
    @(posedge clk);
    m_reset = 0; m_arm = 0; m_we = 0;
    if (pop) void'(q.pop_front());
    if (v) begin
      addr = int'(d[5:0]);
      op   = int'(u[3:2]);
      arg  = int'(u[7:4]);
      if (!d[7] && addr == 63) begin
        m_reset = 1; m_stage_v = 0; reset_seen++;
      end else if (!d[7] && addr == 62) begin
        m_arm = 1;
      end else if (!d[7] && addr == 61) begin
        if (op == 3) begin
          m_stage = arg; m_stage_v = 1;
        end else begin
          m_we = 1; m_op = op;
          m_data = (m_stage_v ? m_stage * 16 : 0) + arg;
          m_stage_v = 0;
        end
      end else if (q.size() < 4) begin
        q.push_back(d);
      end else if (m_drops < 255) begin
        m_drops++;
      end
    end
    #1;
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && q.size() > 0; i++) step(0, 8'h00, 8'h00, 1);
    chk("drained", 32'(fifo_level), 32'd0);
  endtask

  initial begin
    int prefix_start;
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    check_all();
    chk("reset_ev_valid", 32'(ev_valid), 32'd0);

    // Spike into empty FIFO
    step(1, 8'h05, 8'h00, 0);
    chk("first_addr", 32'(ev_addr), 32'd5);
    chk("first_level", 32'(fifo_level), 32'd1);

    // Tick on reserved address is an event; plain reserved is a command
    step(1, 8'hBF, 8'h00, 0);
    chk("tick_rsv_no_cmd", 32'(cmd_reset), 32'd0);
    step(1, 8'h3F, 8'h00, 0);
    chk("cmd_reset_pulse", 32'(cmd_reset), 32'd1);
    chk("cmd_level_same", 32'(fifo_level), 32'd2);
    step(0, 8'h00, 8'h00, 0);
    step(1, 8'h3E, 8'h00, 0);
    step(0, 8'h00, 8'h00, 0);

    // Config assembly
    step(1, 8'h3D, 8'hAC, 0);
    chk("prefix_no_we", 32'(cfg_we), 32'd0);
    step(1, 8'h3D, 8'h54, 0);
    chk("cfg_a5", 32'(cfg_data), 32'hA5);
    step(1, 8'h3D, 8'h78, 0);
    chk("cfg_07", 32'(cfg_data), 32'h07);
    step(0, 8'h00, 8'h00, 0);

    // Prefix cancelled by reset command
    prefix_start = reset_seen;
    step(1, 8'h3D, 8'hCC, 0);
    step(1, 8'h3F, 8'h00, 0);
    step(1, 8'h3D, 8'h30, 0);
    chk("cfg_03", 32'(cfg_data), 32'h03);
    chk("reset_once", 32'(reset_seen - prefix_start), 32'd1);
    drain();

    // Overflow
    for (int a = 1; a <= 6; a++) step(1, 8'(a), 8'h00, 0);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_drops", 32'(drop_count), 32'd2);
    drain();
    for (int a = 1; a <= 4; a++) step(1, 8'(a + 16), 8'h00, 0);
    for (int i = 0; i < 300; i++) step(1, 8'h0A, 8'h00, 0);
    chk("drop_sat", 32'(drop_count), 32'd255);

    // Full with concurrent pop
    step(1, 8'h09, 8'h00, 1);
    chk("full_pop_level", 32'(fifo_level), 32'd4);
    chk("full_pop_drops", 32'(drop_count), 32'd255);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 8'h00, 1);
    chk("nine_last", 32'(ev_addr), 32'd9);
    drain();

    // Random stream
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      logic [7:0] u;
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) d[5:0] = 6'(61 + $urandom_range(0, 2));
      u = 8'($urandom);
      step(($urandom_range(0, 3) != 0), d, u, ($urandom_range(0, 2) != 0));
    end

    // Async reset mid-stream
    step(1, 8'h11, 8'h00, 0);
    step(1, 8'h12, 8'h00, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ev_valid", 32'(ev_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    step(1, 8'h3D, 8'h14, 0);
    chk("post_rst_cfg", 32'(cfg_data), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
